// File: rtl/reset_button_ctrl.sv
// reset_button_ctrl
//   Board-level active-low reset generator. Holds sys_reset_n low for a
//   power-on interval, then follows a debounced active-low pushbutton: a
//   debounced press asserts reset, and a debounced release starts a fixed
//   stretch before reset is released again. sys_reset_n is registered, so
//   its deassertion is always synchronous to clk.
//
// Ports
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset (power-on / PLL lock)
//   btn_n        in   raw pushbutton, active-low, asynchronous, bouncy
//   sys_reset_n  out  registered active-low reset to downstream stages
//   btn_pressed  out  debounced button level, 1 = pressed
//   press_pulse  out  one-clock strobe on each debounced press
module reset_button_ctrl #(
    parameter int unsigned POR_CYCLES      = 1024,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned STRETCH_CYCLES  = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n,
    output logic sys_reset_n,
    output logic btn_pressed,
    output logic press_pulse
);

    localparam int unsigned MAX_A      = (POR_CYCLES > DEBOUNCE_CYCLES) ? POR_CYCLES : DEBOUNCE_CYCLES;
    localparam int unsigned MAX_CYCLES = (MAX_A > STRETCH_CYCLES) ? MAX_A : STRETCH_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STR_LAST = CNT_W'(STRETCH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_POR,
        ST_RUN,
        ST_HOLD,
        ST_STRETCH
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             sync1;
    logic             btn_sync;
    logic             btn_db;      // debounced level, active-low like btn_n
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] st_cnt;
    logic             db_pressed;

    assign db_pressed = ~btn_db;

    // Two-flop synchroniser; btn_n goes straight into the first flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= 1'b1;
            btn_sync <= 1'b1;
        end else begin
            sync1    <= btn_n;
            btn_sync <= sync1;
        end
    end

    // Debounce: a level change is accepted only after DEBOUNCE_CYCLES
    // consecutive mismatching samples; any agreement restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_db  <= 1'b1;
            deb_cnt <= '0;
        end else if (btn_sync == btn_db) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            btn_db  <= btn_sync;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + CNT_W'(1);
        end
    end

    // btn_pressed holds last cycle's debounced level, so a rising edge of
    // the debounced press is detected against it without an extra flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_pressed <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            btn_pressed <= db_pressed;
            press_pulse <= db_pressed & ~btn_pressed;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_POR;
            st_cnt      <= '0;
            sys_reset_n <= 1'b0;
        end else begin
            state       <= state_next;
            sys_reset_n <= (state_next == ST_RUN);
            // Shared counter: cleared on every state entry, counts only in
            // POR and STRETCH, so it stays at zero in RUN and HOLD.
            if (state_next != state) begin
                st_cnt <= '0;
            end else if (state == ST_POR || state == ST_STRETCH) begin
                st_cnt <= st_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_POR: begin
                if (st_cnt == POR_LAST) begin
                    state_next = db_pressed ? ST_HOLD : ST_RUN;
                end
            end
            ST_RUN: begin
                if (db_pressed) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!db_pressed) begin
                    state_next = ST_STRETCH;
                end
            end
            ST_STRETCH: begin
                if (db_pressed) begin
                    state_next = ST_HOLD;
                end else if (st_cnt == STR_LAST) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_POR;
        endcase
    end

endmodule

// File: tb/tb_reset_button_ctrl.sv
// tb_reset_button_ctrl
//   Directed-vector bench for reset_button_ctrl. Expected outputs are packed
//   as {sys_reset_n, btn_pressed, press_pulse}. A second instance with a long
//   stretch interval is used where a debounced re-press must land inside
//   STRETCH, which the short stretch cannot accommodate.
module tb_reset_button_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    logic btn_n;

    logic sys_reset_n, btn_pressed, press_pulse;
    logic sys_reset_n_l, btn_pressed_l, press_pulse_l;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #20 clk = ~clk;

    reset_button_ctrl #(
        .POR_CYCLES      (16),
        .DEBOUNCE_CYCLES (8),
        .STRETCH_CYCLES  (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_n       (btn_n),
        .sys_reset_n (sys_reset_n),
        .btn_pressed (btn_pressed),
        .press_pulse (press_pulse)
    );

    reset_button_ctrl #(
        .POR_CYCLES      (16),
        .DEBOUNCE_CYCLES (8),
        .STRETCH_CYCLES  (16)
    ) dut_long (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_n       (btn_n),
        .sys_reset_n (sys_reset_n_l),
        .btn_pressed (btn_pressed_l),
        .press_pulse (press_pulse_l)
    );

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got {rst,btn,pulse}=%b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic [2:0] exp, input bit use_long, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            if (use_long)
                check(tag, {sys_reset_n_l, btn_pressed_l, press_pulse_l}, exp);
            else
                check(tag, {sys_reset_n, btn_pressed, press_pulse}, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        btn_n   = 1'b1;
        #5;
        check("reset_values", {sys_reset_n, btn_pressed, press_pulse}, 3'b000);
        tick();
        tick();

        // 1. POR with button idle: 16 clocks low, then released.
        reset_n = 1'b1;
        run(15, 3'b000, 1'b0, "por_hold");
        run(1,  3'b100, 1'b0, "por_end");
        run(4,  3'b100, 1'b0, "run_idle");

        // 2. Clean press in RUN, held 20 clocks, then release.
        btn_n = 1'b0;
        run(10, 3'b100, 1'b0, "press_latency");
        run(1,  3'b011, 1'b0, "press_assert");
        run(9,  3'b010, 1'b0, "press_hold");
        btn_n = 1'b1;
        run(10, 3'b010, 1'b0, "release_debounce");
        run(4,  3'b000, 1'b0, "release_stretch");
        run(1,  3'b100, 1'b0, "release_deassert");
        run(4,  3'b100, 1'b0, "release_run");

        // 3. Bounce every 3 clocks for 30 clocks: nothing may change.
        for (int i = 0; i < 10; i++) begin
            btn_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            run(3, 3'b100, 1'b0, "bounce");
        end
        btn_n = 1'b1;
        run(12, 3'b100, 1'b0, "bounce_settle");
        run(1,  3'b100, 1'b1, "long_idle");

        // 4. Re-press during STRETCH (long-stretch instance).
        btn_n = 1'b0;
        run(10, 3'b100, 1'b1, "l_press_latency");
        run(1,  3'b011, 1'b1, "l_press_assert");
        run(5,  3'b010, 1'b1, "l_press_hold");
        btn_n = 1'b1;
        run(8,  3'b010, 1'b1, "l_release_debounce");
        btn_n = 1'b0;
        run(2,  3'b010, 1'b1, "l_release_commit");
        run(8,  3'b000, 1'b1, "l_stretch_repress");
        run(1,  3'b011, 1'b1, "l_back_to_hold");
        run(5,  3'b010, 1'b1, "l_hold_again");
        btn_n = 1'b1;
        run(10, 3'b010, 1'b1, "l_final_debounce");
        run(16, 3'b000, 1'b1, "l_final_stretch");
        run(1,  3'b100, 1'b1, "l_final_deassert");

        // 5. Button held through POR; async reset taken from RUN.
        run(2, 3'b100, 1'b0, "pre_reset_run");
        #10;
        reset_n = 1'b0;
        btn_n   = 1'b0;
        #1;
        check("async_reset_from_run", {sys_reset_n, btn_pressed, press_pulse}, 3'b000);
        tick();
        reset_n = 1'b1;
        run(10, 3'b000, 1'b0, "por_btn_debounce");
        run(1,  3'b011, 1'b0, "por_btn_pulse");
        run(9,  3'b010, 1'b0, "por_to_hold");
        btn_n = 1'b1;
        run(10, 3'b010, 1'b0, "por_rel_debounce");
        run(4,  3'b000, 1'b0, "por_rel_stretch");
        run(1,  3'b100, 1'b0, "por_rel_deassert");

        // 6. reset_n pulsed mid-STRETCH, full POR afterwards.
        btn_n = 1'b0;
        run(10, 3'b100, 1'b0, "r6_press_latency");
        run(1,  3'b011, 1'b0, "r6_press_assert");
        run(4,  3'b010, 1'b0, "r6_hold");
        btn_n = 1'b1;
        run(10, 3'b010, 1'b0, "r6_release_debounce");
        run(2,  3'b000, 1'b0, "r6_in_stretch");
        #10;
        reset_n = 1'b0;
        #1;
        check("async_reset_stretch", {sys_reset_n, btn_pressed, press_pulse}, 3'b000);
        check("async_reset_stretch_long", {sys_reset_n_l, btn_pressed_l, press_pulse_l}, 3'b000);
        tick();
        tick();
        reset_n = 1'b1;
        run(15, 3'b000, 1'b0, "r6_por_hold");
        run(1,  3'b100, 1'b0, "r6_por_end");
        run(3,  3'b100, 1'b0, "r6_run");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
